// File: rtl/ddr3_pg_ring_sched.sv
// Page-ring scheduler in front of the DDR3 page transfer controller.
// Treats DDR3 as a circular buffer of N_PAGES fixed-size pages. It accepts
// producer store requests and consumer fetch requests, arbitrates between
// them, and runs the pg_req/pg_ack handshake with the transfer controller.
module ddr3_pg_ring_sched #(
    parameter int unsigned N_PAGES        = 1024,
    parameter int unsigned PG_ADDR_STRIDE = 2048,
    parameter logic [27:0] BASE_ADDR      = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_pg_req,
    output logic                         wr_pg_done,
    input  logic                         rd_pg_req,
    output logic                         rd_pg_done,
    input  logic                         flush,
    output logic                         pg_req,
    output logic                         pg_optype,
    output logic [27:0]                  pg_req_addr,
    input  logic                         pg_ack,
    output logic [$clog2(N_PAGES)-1:0]   wr_ptr,
    output logic [$clog2(N_PAGES)-1:0]   rd_ptr,
    output logic [$clog2(N_PAGES):0]     pg_count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(N_PAGES);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(N_PAGES);
    localparam logic [27:0]   STRIDE   = 28'(PG_ADDR_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_DONE,
        S_GUARD
    } state_t;

    state_t          state_q, state_d;
    logic            pg_req_q, pg_req_d;
    logic            pg_optype_q, pg_optype_d;
    logic [27:0]     pg_req_addr_q, pg_req_addr_d;
    logic            wr_pg_done_q, wr_pg_done_d;
    logic            rd_pg_done_q, rd_pg_done_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   pg_count_q, pg_count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            last_wr_q, last_wr_d;      // 1 = last served was a write
    logic            flush_pend_q, flush_pend_d;

    logic            wr_ok, rd_ok;
    logic [27:0]     wr_addr, rd_addr;

    // Slot start addresses, truncated to the 28-bit app address space
    always_comb begin
        wr_addr = BASE_ADDR + 28'(wr_ptr_q) * STRIDE;
        rd_addr = BASE_ADDR + 28'(rd_ptr_q) * STRIDE;
    end

    // Next-state, handshake and ring bookkeeping
    always_comb begin
        state_d       = state_q;
        pg_req_d      = pg_req_q;
        pg_optype_d   = pg_optype_q;
        pg_req_addr_d = pg_req_addr_q;
        wr_pg_done_d  = 1'b0;
        rd_pg_done_d  = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pg_count_d    = pg_count_q;
        last_wr_d     = last_wr_q;
        flush_pend_d  = flush_pend_q;
        // full/empty lag the count by one cycle; eligibility also checks the
        // live count so a flush can never open a window for a bogus request
        full_d        = (pg_count_q == FULL_CNT);
        empty_d       = (pg_count_q == '0);
        wr_ok         = wr_pg_req && !full_q && (pg_count_q != FULL_CNT);
        rd_ok         = rd_pg_req && !empty_q && (pg_count_q != '0);

        if (flush && (state_q != S_IDLE)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    pg_count_d = '0;
                end else if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    pg_optype_d   = 1'b1;
                    pg_req_addr_d = wr_addr;
                    pg_req_d      = 1'b1;
                    state_d       = S_REQ;
                end else if (rd_ok) begin
                    pg_optype_d   = 1'b0;
                    pg_req_addr_d = rd_addr;
                    pg_req_d      = 1'b1;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                if (pg_ack) begin
                    pg_req_d = 1'b0;
                    state_d  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!pg_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (pg_optype_q) begin
                    wr_pg_done_d = 1'b1;
                    wr_ptr_d     = wr_ptr_q + PW'(1);
                    pg_count_d   = pg_count_q + CW'(1);
                end else begin
                    rd_pg_done_d = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PW'(1);
                    pg_count_d   = pg_count_q - CW'(1);
                end
                last_wr_d = pg_optype_q;
                state_d   = S_GUARD;
            end
            S_GUARD: begin
                if (flush_pend_q || flush) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    pg_count_d = '0;
                end
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pg_req_q      <= 1'b0;
            pg_optype_q   <= 1'b0;
            pg_req_addr_q <= '0;
            wr_pg_done_q  <= 1'b0;
            rd_pg_done_q  <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pg_count_q    <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            last_wr_q     <= 1'b0;
            flush_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pg_req_q      <= pg_req_d;
            pg_optype_q   <= pg_optype_d;
            pg_req_addr_q <= pg_req_addr_d;
            wr_pg_done_q  <= wr_pg_done_d;
            rd_pg_done_q  <= rd_pg_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pg_count_q    <= pg_count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            last_wr_q     <= last_wr_d;
            flush_pend_q  <= flush_pend_d;
        end
    end

    assign pg_req      = pg_req_q;
    assign pg_optype   = pg_optype_q;
    assign pg_req_addr = pg_req_addr_q;
    assign wr_pg_done  = wr_pg_done_q;
    assign rd_pg_done  = rd_pg_done_q;
    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign pg_count    = pg_count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_ddr3_pg_ring_sched.sv
// Bench for ddr3_pg_ring_sched: 4-slot ring at a non-zero base address,
// behavioural transfer-controller responder, request scoreboard.
module tb_ddr3_pg_ring_sched;

    localparam int unsigned   NP   = 4;
    localparam logic [27:0]   BASE = 28'h100000;
    localparam int unsigned   STR  = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pg_req, rd_pg_req, flush, pg_ack;
    logic        wr_pg_done, rd_pg_done, pg_req, pg_optype;
    logic [27:0] pg_req_addr;
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  pg_count;
    logic        full, empty;

    ddr3_pg_ring_sched #(
        .N_PAGES(NP),
        .PG_ADDR_STRIDE(STR),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_pg_req(wr_pg_req), .wr_pg_done(wr_pg_done),
        .rd_pg_req(rd_pg_req), .rd_pg_done(rd_pg_done),
        .flush(flush),
        .pg_req(pg_req), .pg_optype(pg_optype), .pg_req_addr(pg_req_addr),
        .pg_ack(pg_ack),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .pg_count(pg_count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        optype;
        logic [27:0] addr;
    } exp_t;

    typedef struct {
        bit          is_wr;
        logic [27:0] addr;
        int unsigned wr_ptr;
        int unsigned rd_ptr;
        int unsigned cnt;
        bit          full;
        bit          empty;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    int n_vec  = 0;
    int n_fail = 0;

    int ack_delay = 10;
    bit ack_en    = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int unsigned w, input int unsigned r,
                             input int unsigned c, input bit f, input bit e);
        chk({tag, "_wr_ptr"}, 32'(wr_ptr), w);
        chk({tag, "_rd_ptr"}, 32'(rd_ptr), r);
        chk({tag, "_count"}, 32'(pg_count), c);
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pg_req"}, 32'(pg_req), 0);
        chk({tag, "_optype"}, 32'(pg_optype), 0);
        chk({tag, "_addr"}, 32'(pg_req_addr), 0);
        chk({tag, "_wr_done"}, 32'(wr_pg_done), 0);
        chk({tag, "_rd_done"}, 32'(rd_pg_done), 0);
        chk_state(tag, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a done pulse of the given type; a pulse of the other type is a miscompare
    task automatic wait_done(input bit is_wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_wr ? wr_pg_done : rd_pg_done) begin
                ok = 1'b1;
                break;
            end
            if (is_wr ? rd_pg_done : wr_pg_done) begin
                n_vec++;
                n_fail++;
                $display("FAIL wrong_done: got done of type %0d, required type %0d", !is_wr, is_wr);
            end
        end
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL done_timeout: got no done pulse, required one within 300 cycles");
        end
    endtask

    task automatic wait_any_done(output bit got_wr, output bit ok);
        ok = 1'b0;
        got_wr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wr_pg_done || rd_pg_done) begin
                ok = 1'b1;
                got_wr = wr_pg_done;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL any_done_timeout: got no done pulse, required one within 300 cycles");
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pg_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_seen", 32'(ok), 1);
    endtask

    // One complete page transfer driven from a table row
    task automatic xfer(input vec_t v, input string tag);
        bit ok;
        if (v.is_wr) wr_pg_req = 1'b1; else rd_pg_req = 1'b1;
        exp_q.push_back('{optype: v.is_wr, addr: v.addr});
        wait_done(v.is_wr, ok);
        wr_pg_req = 1'b0;
        rd_pg_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(v.is_wr ? wr_pg_done : rd_pg_done), 0);
        chk_state(tag, v.wr_ptr, v.rd_ptr, v.cnt, v.full, v.empty);
    endtask

    // Transfer-controller model: ack after ack_delay cycles, release after pg_req drops
    initial begin
        int ack_cnt;
        pg_ack  = 1'b0;
        ack_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pg_ack  = 1'b0;
                ack_cnt = 0;
            end else if (!pg_ack) begin
                if (pg_req && ack_en) begin
                    ack_cnt++;
                    if (ack_cnt >= ack_delay) begin
                        pg_ack  = 1'b1;
                        ack_cnt = 0;
                    end
                end else begin
                    ack_cnt = 0;
                end
            end else if (!pg_req) begin
                pg_ack = 1'b0;
            end
        end
    end

    // Scoreboard: each pg_req rise pops the next expected request; held fields must stay stable
    initial begin
        exp_t        e;
        logic        prev_req;
        logic        cap_opt;
        logic [27:0] cap_addr;
        prev_req = 1'b0;
        cap_opt  = 1'b0;
        cap_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (pg_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_pg_req: got optype %0d addr %0h, required no request",
                                 pg_optype, pg_req_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_optype", 32'(pg_optype), 32'(e.optype));
                        chk("req_addr", 32'(pg_req_addr), 32'(e.addr));
                    end
                    cap_opt  = pg_optype;
                    cap_addr = pg_req_addr;
                end else if (pg_req && prev_req) begin
                    chk("req_stable_optype", 32'(pg_optype), 32'(cap_opt));
                    chk("req_stable_addr", 32'(pg_req_addr), 32'(cap_addr));
                end
                prev_req = pg_req;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok, got_wr, seen;
        bit arb_exp[4];

        //                 is_wr addr            wr rd cnt full empty
        vecs[0] = '{1'b1, 28'h100000, 1, 0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 28'h100800, 2, 0, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 28'h101000, 3, 0, 3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 28'h100000, 3, 1, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 28'h100800, 3, 2, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 28'h101800, 0, 2, 2, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 28'h100000, 1, 2, 3, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 28'h100800, 2, 2, 4, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 28'h101000, 2, 3, 3, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 28'h101800, 2, 0, 2, 1'b0, 1'b0};
        arb_exp = '{1'b1, 1'b0, 1'b1, 1'b0};

        wr_pg_req = 1'b0;
        rd_pg_req = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table: writes, reads and pointer wrap
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Both requests held: alternate starting with write (last served was a read)
        wr_pg_req = 1'b1;
        rd_pg_req = 1'b1;
        exp_q.push_back('{optype: 1'b1, addr: 28'h101000});
        exp_q.push_back('{optype: 1'b0, addr: 28'h100000});
        exp_q.push_back('{optype: 1'b1, addr: 28'h101800});
        exp_q.push_back('{optype: 1'b0, addr: 28'h100800});
        for (int k = 0; k < 4; k++) begin
            wait_any_done(got_wr, ok);
            if (ok) chk($sformatf("arb_order%0d", k), 32'(got_wr), 32'(arb_exp[k]));
            if (k == 3 || !ok) begin
                wr_pg_req = 1'b0;
                rd_pg_req = 1'b0;
            end
        end
        @(negedge clk);
        chk_state("arb", 0, 2, 2, 1'b0, 1'b0);

        // Fill the ring, then a write request must wait until a read frees a slot
        xfer('{1'b1, 28'h100000, 1, 2, 3, 1'b0, 1'b0}, "fill1");
        xfer('{1'b1, 28'h100800, 2, 2, 4, 1'b1, 1'b0}, "fill2");
        wr_pg_req = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (pg_req) seen = 1'b1;
        end
        chk("full_blocks_write", 32'(seen), 0);
        xfer('{1'b0, 28'h101000, 2, 3, 3, 1'b0, 1'b0}, "unblock_rd");
        wr_pg_req = 1'b1;
        exp_q.push_back('{optype: 1'b1, addr: 28'h101000});
        wait_done(1'b1, ok);
        wr_pg_req = 1'b0;
        @(negedge clk);
        chk_state("pending_wr", 3, 3, 4, 1'b1, 1'b0);

        // Flush while the read is in S_REQ: transfer completes, then ring is emptied
        rd_pg_req = 1'b1;
        exp_q.push_back('{optype: 1'b0, addr: 28'h101800});
        wait_req(ok);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done(1'b0, ok);
        rd_pg_req = 1'b0;
        @(negedge clk);
        chk("flush_req_wr_ptr", 32'(wr_ptr), 0);
        chk("flush_req_rd_ptr", 32'(rd_ptr), 0);
        chk("flush_req_count", 32'(pg_count), 0);
        @(negedge clk);
        chk("flush_req_empty", 32'(empty), 1);
        chk("flush_req_full", 32'(full), 0);

        // Read request on an empty ring never reaches the transfer controller
        do_reset();
        rd_pg_req = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (pg_req) seen = 1'b1;
        end
        chk("empty_blocks_read", 32'(seen), 0);
        rd_pg_req = 1'b0;
        @(negedge clk);

        // Flush in S_IDLE suppresses a request in the same cycle
        xfer('{1'b1, 28'h100000, 1, 0, 1, 1'b0, 1'b0}, "pre_flush");
        flush     = 1'b1;
        wr_pg_req = 1'b1;
        exp_q.push_back('{optype: 1'b1, addr: 28'h100000});
        @(negedge clk);
        flush = 1'b0;
        chk("idle_flush_no_req", 32'(pg_req), 0);
        chk("idle_flush_wr_ptr", 32'(wr_ptr), 0);
        chk("idle_flush_count", 32'(pg_count), 0);
        wait_done(1'b1, ok);
        wr_pg_req = 1'b0;
        @(negedge clk);
        chk_state("post_flush_wr", 1, 0, 1, 1'b0, 1'b0);

        // Reset while parked in S_REQ: request drops, no done pulse
        ack_en    = 1'b0;
        wr_pg_req = 1'b1;
        exp_q.push_back('{optype: 1'b1, addr: 28'h100800});
        wait_req(ok);
        rst       = 1'b1;
        wr_pg_req = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        seen   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (wr_pg_done || rd_pg_done || pg_req) seen = 1'b1;
        end
        chk("rst_mid_no_done", 32'(seen), 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_pg_ring_sched.md
Name: ddr3_pg_ring_sched

Overview:
- Upstream scheduler for DDR3_pg_transfer_ctrl. It manages DDR3 as a circular buffer of fixed-size pages.
- Accepts "page ready in DPRAM, store it" requests from the write-side producer and "fetch next page into DPRAM" requests from the read-side consumer.
- Arbitrates between the two and drives the pg_req/pg_optype/pg_req_addr/pg_ack handshake of the transfer controller.
- Tracks head and tail page pointers plus the occupancy count, and reports full/empty.

Parameters:
- N_PAGES, 1024: number of page slots in the DDR3 ring. Power of two, ≥2.
- PG_ADDR_STRIDE, 2048: DDR3 app address units per page (256 bursts × 8).
- BASE_ADDR, 0: 28-bit DDR3 app address of page slot 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_pg_req  in  1  level; producer has a full DPRAM page to store
- wr_pg_done  out  1  1-cycle pulse; page written to DDR3
- rd_pg_req  in  1  level; consumer wants the next stored page in DPRAM
- rd_pg_done  out  1  1-cycle pulse; page read into DPRAM
- flush  in  1  1-cycle pulse; empty the ring
- pg_req  out  1  to transfer ctrl
- pg_optype  out  1  0 = read (DDR3→DPRAM), 1 = write (DPRAM→DDR3)
- pg_req_addr  out  28  DDR3 start address of the page
- pg_ack  in  1  from transfer ctrl
- wr_ptr  out  log2(N_PAGES)  next slot to be written
- rd_ptr  out  log2(N_PAGES)  next slot to be read
- pg_count  out  log2(N_PAGES)+1  occupied slots
- full  out  1  pg_count == N_PAGES
- empty  out  1  pg_count == 0

Behaviour:
- Reset values: pg_req=0, pg_optype=0, pg_req_addr=0, wr_pg_done=0, rd_pg_done=0, wr_ptr=0, rd_ptr=0, pg_count=0, full=0, empty=1. FSM returns to S_IDLE.
- Reset mid-operation aborts immediately: pg_req drops the next cycle and no done pulse is issued. The transfer ctrl shares the same rst.
- FSM states: S_IDLE, S_REQ, S_RELEASE, S_DONE, S_GUARD.
- S_IDLE:
  - A write is eligible when wr_pg_req && !full.
  - A read is eligible when rd_pg_req && !empty.
  - If exactly one is eligible, select it.
  - If both are eligible, select the type opposite to the last one served. The last-served flag resets to "read", so write wins first.
  - On selection, register pg_optype and pg_req_addr = BASE_ADDR + ptr × PG_ADDR_STRIDE, using wr_ptr for writes and rd_ptr for reads. Truncate to 28 bits.
  - Set pg_req=1 and go to S_REQ. pg_req rises one cycle after an eligible request is sampled.
- S_REQ: hold pg_req, pg_optype and pg_req_addr stable until pg_ack=1 is sampled. Then set pg_req=0 and go to S_RELEASE.
- S_RELEASE: wait for pg_ack=0, then go to S_DONE.
- S_DONE:
  - Pulse the matching done output for exactly 1 cycle.
  - Write: wr_ptr += 1 (wraps modulo N_PAGES), pg_count += 1.
  - Read: rd_ptr += 1 (wraps), pg_count -= 1.
  - Record last-served type. Go to S_GUARD.
- S_GUARD: one idle cycle so the requester can drop its level request after seeing done. Then go to S_IDLE.
  - Requester contract: deassert the request within 1 cycle of done, or it is treated as a new request.
- full/empty are registered and update the cycle after the pointer update.
- No request is ever issued for a write while full or a read while empty. The pending request simply waits; nothing is dropped.
- flush:
  - In S_IDLE: wr_ptr=rd_ptr=0 and pg_count=0 on the next cycle. No request is started that cycle.
  - In any other state: latch a pending-flush flag and apply it in S_GUARD after the pointer update. The in-flight transfer completes and its done pulse is still issued.
- Pointer and count arithmetic is unsigned. pg_count never exceeds N_PAGES and never underflows.

Test Plan:
- Single write: reset, wr_pg_req=1 → pg_req=1, pg_optype=1, pg_req_addr=0. Model acks after 10 cycles and releases → wr_pg_done 1 pulse, wr_ptr=1, pg_count=1, empty=0.
- Write then read: 3 writes then rd_pg_req → read addresses 0; second read addr 2048. rd_ptr=2, pg_count=1 after two reads.
- Arbitration: both reqs held with pg_count=2 → served order write, read, write, read. pg_optype alternates 1,0,1,0.
- Full/empty boundaries, N_PAGES=4: after 4 writes full=1 and a 5th wr_pg_req gets no pg_req until a read completes. Reset, then rd_pg_req with empty=1 → pg_req stays 0 for 100 cycles.
- Wrap: N_PAGES=4, BASE_ADDR=0x100000. 6 writes interleaved with 4 reads → 5th write uses addr 0x100000, wr_ptr sequence 0,1,2,3,0,1.
- Flush and reset mid-transfer:
  - flush while in S_REQ → transfer completes, done pulses, then pg_count=0, pointers 0.
  - rst asserted while in S_REQ → pg_req=0 next cycle, no done pulse, all outputs at reset values.
